// File: rtl/z80_bus_cycle_gen.sv
// Z80 memory bus initiator: opcode fetch (M1 + refresh), memory read and memory write
// with half-T-state phasing. Refresh after fetch is enabled by defining Z80_REFRESH_EN.
module z80_bus_cycle_gen #(
    parameter logic [7:0] REFRESH_HI = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [1:0]  cyc,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        nwait,
    input  logic [7:0]  din,
    output logic        ready,
    output logic        done,
    output logic [7:0]  rdata,
    output logic [15:0] a,
    output logic [7:0]  dout,
    output logic        doe,
    output logic        nmreq,
    output logic        nrd,
    output logic        nwr,
    output logic        nm1,
    output logic        nrfsh,
    output logic [6:0]  rreg
);

`ifdef Z80_REFRESH_EN
    localparam bit RFSH_EN = 1'b1;
`else
    localparam bit RFSH_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, T1H, T1L, T2H, T2L, TWH, TWL, T3H, T3L, T4H, T4L
    } state_t;

    state_t      st_reg;
    logic        is_fetch_reg;
    logic        is_write_reg;
    logic [15:0] addr_reg;
    logic [7:0]  wdata_reg;
    logic        rfsh_end_reg;

    // Bus pins are registered from the phase held in st_reg, so they trail the state by one clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_reg       <= IDLE;
            is_fetch_reg <= 1'b0;
            is_write_reg <= 1'b0;
            addr_reg     <= 16'h0000;
            wdata_reg    <= 8'h00;
            rfsh_end_reg <= 1'b0;
            ready        <= 1'b1;
            done         <= 1'b0;
            rdata        <= 8'h00;
            a            <= 16'h0000;
            dout         <= 8'h00;
            doe          <= 1'b0;
            nmreq        <= 1'b1;
            nrd          <= 1'b1;
            nwr          <= 1'b1;
            nm1          <= 1'b1;
            nrfsh        <= 1'b1;
            rreg         <= 7'd0;
        end else begin
            done <= 1'b0;
            if (rfsh_end_reg) begin
                rreg         <= rreg + 7'd1;
                rfsh_end_reg <= 1'b0;
            end

            case (st_reg)
                IDLE: begin
                    nmreq <= 1'b1;
                    nrd   <= 1'b1;
                    nwr   <= 1'b1;
                    nm1   <= 1'b1;
                    nrfsh <= 1'b1;
                    doe   <= 1'b0;
                end
                T1H: begin
                    a     <= addr_reg;
                    nm1   <= ~is_fetch_reg;
                    nmreq <= 1'b1;
                    nrd   <= 1'b1;
                    nwr   <= 1'b1;
                    nrfsh <= 1'b1;
                    doe   <= 1'b0;
                end
                T1L: begin
                    nmreq <= 1'b0;
                    if (is_write_reg) begin
                        doe  <= 1'b1;
                        dout <= wdata_reg;
                    end else begin
                        nrd <= 1'b0;
                    end
                end
                T2L: begin
                    if (is_write_reg) begin
                        nwr <= 1'b0;
                    end
                end
                T3H: begin
                    if (is_fetch_reg) begin
                        rdata <= din;
                        done  <= 1'b1;
                        nmreq <= 1'b1;
                        nrd   <= 1'b1;
                        nm1   <= 1'b1;
                        if (RFSH_EN) begin
                            nrfsh <= 1'b0;
                            a     <= {REFRESH_HI, 1'b0, rreg};
                        end
                    end
                end
                T3L: begin
                    if (is_fetch_reg) begin
                        if (RFSH_EN) begin
                            nmreq <= 1'b0;
                        end
                    end else begin
                        nmreq <= 1'b1;
                        nrd   <= 1'b1;
                        nwr   <= 1'b1;
                        done  <= 1'b1;
                        if (!is_write_reg) begin
                            rdata <= din;
                        end
                    end
                end
                T4L: begin
                    if (is_fetch_reg) begin
                        nmreq <= 1'b1;
                        if (RFSH_EN) begin
                            rfsh_end_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase

            // ready is high exactly in IDLE and the final phase, so it doubles as the accept gate.
            if (ready) begin
                if (req) begin
                    st_reg       <= T1H;
                    ready        <= 1'b0;
                    is_fetch_reg <= (cyc == 2'b00);
                    is_write_reg <= (cyc == 2'b10);
                    addr_reg     <= addr;
                    wdata_reg    <= wdata;
                end else begin
                    st_reg <= IDLE;
                end
            end else begin
                case (st_reg)
                    T1H: st_reg <= T1L;
                    T1L: st_reg <= T2H;
                    T2H: st_reg <= T2L;
                    T2L, TWL: st_reg <= nwait ? T3H : TWH;
                    TWH: st_reg <= TWL;
                    T3H: begin
                        st_reg <= T3L;
                        ready  <= ~is_fetch_reg;
                    end
                    T3L: st_reg <= T4H;
                    T4H: begin
                        st_reg <= T4L;
                        ready  <= 1'b1;
                    end
                    default: begin
                        st_reg <= IDLE;
                        ready  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
